// File: rtl/bus_mem_pkg.sv
// Shared types and constants for the bus memory responder.
package bus_mem_pkg;

    localparam int unsigned BUS_ADDR_W = 13;
    localparam int unsigned BUS_DATA_W = 16;

    localparam logic [15:0] OOR_READ_VALUE = 16'hDEAD;

    localparam int unsigned DEF_DONE_ADDR  = 220;
    localparam logic [15:0] DEF_DONE_VALUE = 16'h0060;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/bus_ram.sv
// Single-port synchronous RAM with registered read, written so FPGA tools infer block RAM.
module bus_ram #(
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bus_mem_responder.sv
// Data-bus slave: RAM-backed word reads/writes with programmable wait states and write counter.
// Define BUS_MEM_RESPONDER_DONE_CHECK_EN to enable the hardware completion-signature check.
module bus_mem_responder
    import bus_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = BUS_ADDR_W,
    parameter int unsigned DATA_W      = BUS_DATA_W,
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned DONE_ADDR   = DEF_DONE_ADDR,
    parameter logic [DATA_W-1:0] DONE_VALUE = DATA_W'(DEF_DONE_VALUE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              ack,
    output logic              stall,
    output logic              err,
    output logic [15:0]       wr_count,
    output logic              pass,
    output logic              fail
);

    localparam int unsigned       RAM_AW    = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic [RAM_AW-1:0]   r_addr;
    logic                r_oor;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rd_hold;
    logic [15:0]         r_wr_count;

    logic                w_accept;
    logic                w_ack;
    logic                w_oor_in;
    logic                w_commit;
    logic                w_ram_we;
    logic [RAM_AW-1:0]   w_ram_addr;
    logic [DATA_W-1:0]   w_ram_q;
    logic [DATA_W-1:0]   w_rdata_now;

    assign w_oor_in = ({1'b0, DataAdr} >= DEPTH_LIM);

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_ack    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = (WAIT_STATES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next = ACK;
                end
            end
            ACK: begin
                w_ack  = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // In IDLE the RAM is addressed straight from the bus so a zero-wait read has data in ACK.
    assign w_ram_addr  = (r_state == IDLE) ? DataAdr[RAM_AW-1:0] : r_addr;
    assign w_commit    = w_ack & r_write & ~r_oor;
    assign w_ram_we    = w_commit & reset;
    assign w_rdata_now = r_write ? '0 : (r_oor ? DATA_W'(OOR_READ_VALUE) : w_ram_q);

    bus_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rd_hold  <= '0;
            r_wr_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= DataAdr[RAM_AW-1:0];
                r_oor   <= w_oor_in;
                r_write <= MemWrite;
                r_wdata <= WriteData;
                r_cnt   <= 4'(WAIT_STATES);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_ack) begin
                r_rd_hold <= w_rdata_now;
            end
            if (w_commit && (r_wr_count != '1)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

`ifdef BUS_MEM_RESPONDER_DONE_CHECK_EN
    localparam logic [RAM_AW-1:0] DONE_IDX = RAM_AW'(DONE_ADDR);
    localparam bit                DONE_OK  = (DONE_ADDR < DEPTH);

    logic r_pass;
    logic r_fail;
    logic w_done_hit;

    assign w_done_hit = DONE_OK && (r_addr == DONE_IDX);

    // Only the first signature write decides; both flags stay frozen afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (w_commit && w_done_hit && !r_pass && !r_fail) begin
            if (r_wdata == DONE_VALUE) begin
                r_pass <= 1'b1;
            end else begin
                r_fail <= 1'b1;
            end
        end
    end

    assign pass = r_pass;
    assign fail = r_fail;
`else
    logic w_unused_done_cfg;
    assign w_unused_done_cfg = ^{ADDR_W'(DONE_ADDR), DONE_VALUE};
    assign pass = 1'b0;
    assign fail = 1'b0;
`endif

    assign ack      = w_ack;
    assign err      = w_ack & r_oor;
    assign stall    = req_valid & ~w_ack;
    assign ReadData = w_ack ? w_rdata_now : r_rd_hold;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench: two responders (2 and 0 wait states) on shared bus inputs against a transaction-level model.
module tb_bus_mem_responder;

    localparam int unsigned DEPTH = 2048;
`ifdef BUS_MEM_RESPONDER_DONE_CHECK_EN
    localparam bit DONE_EN = 1'b1;
`else
    localparam bit DONE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        MemWrite = 1'b0;
    logic [12:0] DataAdr = '0;
    logic [15:0] WriteData = '0;

    logic [15:0] rd [2];
    logic [15:0] wc [2];
    logic [1:0]  ack, stall, err, pass, fail;

    bus_mem_responder #(.ADDR_W(13), .DATA_W(16), .DEPTH(DEPTH), .WAIT_STATES(2)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(rd[0]), .ack(ack[0]),
        .stall(stall[0]), .err(err[0]), .wr_count(wc[0]), .pass(pass[0]), .fail(fail[0])
    );

    bus_mem_responder #(.ADDR_W(13), .DATA_W(16), .DEPTH(DEPTH), .WAIT_STATES(0)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData), .ReadData(rd[1]), .ack(ack[1]),
        .stall(stall[1]), .err(err[1]), .wr_count(wc[1]), .pass(pass[1]), .fail(fail[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    function automatic void chk(input string nm, input int d, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", nm, d, act, exp);
        end
    endfunction

    function automatic int ws(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Transaction-level model: a pending request acks exactly ws+1 cycles after acceptance.
    logic [15:0] m_mem   [2][DEPTH];
    bit          m_known [2][DEPTH];
    bit          m_pend [2];
    int          m_ackn [2];
    bit          m_w    [2];
    int unsigned m_a    [2];
    logic [15:0] m_d    [2];
    logic [15:0] m_hold [2];
    bit          m_hold_known [2];
    int unsigned m_wrc  [2];
    bit          m_pass [2];
    bit          m_fail [2];
    int          n = 0;
    bit          started = 1'b0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 0; m_hold[d] = '0; m_hold_known[d] = 1;
            m_wrc[d] = 0; m_pass[d] = 0; m_fail[d] = 0;
            for (int i = 0; i < int'(DEPTH); i++) m_known[d][i] = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                bit a_now, oor, known;
                logic [15:0] exp_rd;
                a_now = m_pend[d] && (n == m_ackn[d]);
                oor   = (m_a[d] >= DEPTH);
                if (a_now) begin
                    if (m_w[d]) begin
                        exp_rd = '0; known = 1;
                    end else if (oor) begin
                        exp_rd = 16'hDEAD; known = 1;
                    end else begin
                        exp_rd = m_mem[d][m_a[d]]; known = m_known[d][m_a[d]];
                    end
                end else begin
                    exp_rd = m_hold[d]; known = m_hold_known[d];
                end
                chk("ack", d, 32'(ack[d]), 32'(a_now));
                chk("err", d, 32'(err[d]), 32'(a_now && oor));
                chk("stall", d, 32'(stall[d]), 32'(req_valid && !a_now));
                chk("wr_count", d, 32'(wc[d]), m_wrc[d]);
                chk("pass", d, 32'(pass[d]), 32'(m_pass[d]));
                chk("fail", d, 32'(fail[d]), 32'(m_fail[d]));
                if (known) chk("ReadData", d, 32'(rd[d]), 32'(exp_rd));

                if (!reset) begin
                    m_pend[d] = 0; m_hold[d] = '0; m_hold_known[d] = 1;
                    m_wrc[d] = 0; m_pass[d] = 0; m_fail[d] = 0;
                end else if (a_now) begin
                    if (m_w[d] && !oor) begin
                        m_mem[d][m_a[d]]   = m_d[d];
                        m_known[d][m_a[d]] = 1;
                        if (m_wrc[d] < 32'hFFFF) m_wrc[d]++;
                        if (DONE_EN && m_a[d] == 220 && !m_pass[d] && !m_fail[d]) begin
                            if (m_d[d] == 16'h0060) m_pass[d] = 1;
                            else m_fail[d] = 1;
                        end
                    end
                    m_hold[d] = exp_rd; m_hold_known[d] = known;
                    m_pend[d] = 0;
                end else if (!m_pend[d] && req_valid) begin
                    m_pend[d] = 1; m_w[d] = MemWrite; m_a[d] = DataAdr;
                    m_d[d] = WriteData; m_ackn[d] = n + ws(d) + 1;
                end
            end
        end
        n++;
    end

    task automatic xact(input int d, input bit w, input logic [12:0] a, input logic [15:0] wd,
                        output logic [15:0] r, output logic e, output int lat);
        bit got;
        @(posedge clk); #1;
        req_valid = 1'b1; MemWrite = w; DataAdr = a; WriteData = wd;
        lat = 0; r = '0; e = 1'b0; got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (ack[d]) begin
                r = rd[d]; e = err[d]; got = 1;
            end else begin
                lat++;
            end
        end
        if (!got) chk("ack_timeout", d, 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    logic [15:0] r;
    logic        e;
    int          lat, c0, c1;
    logic [15:0] saved;

    initial begin
        repeat (2) @(posedge clk);
        #1 started = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ReadData", d, 32'(rd[d]), 32'h0);
            chk("rst_ack", d, 32'(ack[d]), 32'h0);
            chk("rst_wr_count", d, 32'(wc[d]), 32'h0);
        end
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);

        xact(0, 1'b1, 13'd5, 16'h1234, r, e, lat);
        chk("wr5_latency", 0, lat, 3);
        chk("wr5_count", 0, 32'(wc[0]), 32'd1);
        xact(0, 1'b0, 13'd5, 16'h0, r, e, lat);
        chk("rd5_latency", 0, lat, 3);
        chk("rd5_data", 0, 32'(r), 32'h1234);

        xact(1, 1'b1, 13'd7, 16'h0BEE, r, e, lat);
        xact(1, 1'b0, 13'd7, 16'h0, r, e, lat);
        chk("rd7_latency", 1, lat, 1);
        chk("rd7_data", 1, 32'(r), 32'h0BEE);

        @(posedge clk); #1;
        req_valid = 1'b1; MemWrite = 1'b0; DataAdr = 13'd7;
        c0 = 0; c1 = 0;
        repeat (8) begin
            @(negedge clk);
            c0 += int'(ack[0]); c1 += int'(ack[1]);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (5) @(posedge clk);
        chk("b2b_acks", 0, c0, 2);
        chk("b2b_acks", 1, c1, 4);

        xact(0, 1'b0, 13'd4095, 16'h0, r, e, lat);
        chk("oor_rd_data", 0, 32'(r), 32'hDEAD);
        chk("oor_rd_err", 0, 32'(e), 32'd1);
        saved = wc[0];
        xact(0, 1'b1, 13'd4095, 16'h7777, r, e, lat);
        chk("oor_wr_err", 0, 32'(e), 32'd1);
        chk("oor_wr_count", 0, 32'(wc[0]), 32'(saved));

        xact(0, 1'b1, 13'd9, 16'h00AA, r, e, lat);
        @(posedge clk); #1;
        req_valid = 1'b1; MemWrite = 1'b1; DataAdr = 13'd9; WriteData = 16'h5555;
        @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        c0 = 0;
        repeat (6) begin
            @(negedge clk);
            c0 += int'(ack[0]);
        end
        chk("rst_drop_acks", 0, c0, 0);
        xact(0, 1'b0, 13'd9, 16'h0, r, e, lat);
        chk("rst_drop_data", 0, 32'(r), 32'h00AA);
        chk("rst_drop_count", 0, 32'(wc[0]), 32'd0);

        @(posedge clk); #2;
        force dut0.r_wr_count = 16'hFFFE;
        m_wrc[0] = 32'hFFFE;
        #1 release dut0.r_wr_count;
        for (int i = 0; i < 3; i++) xact(0, 1'b1, 13'(10 + i), 16'($urandom), r, e, lat);
        chk("sat_count", 0, 32'(wc[0]), 32'hFFFF);

        xact(0, 1'b1, 13'd220, 16'h0060, r, e, lat);
        chk("done_pass", 0, 32'(pass[0]), 32'(DONE_EN));
        chk("done_fail", 0, 32'(fail[0]), 32'd0);
        xact(0, 1'b1, 13'd220, 16'h0000, r, e, lat);
        chk("done_sticky", 0, 32'(pass[0]), 32'(DONE_EN));
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        xact(0, 1'b1, 13'd220, 16'h0061, r, e, lat);
        chk("done_bad_fail", 0, 32'(fail[0]), 32'(DONE_EN));
        chk("done_bad_pass", 0, 32'(pass[0]), 32'd0);

        for (int k = 0; k < 3000; k++) begin
            int unsigned sel;
            @(posedge clk); #1;
            reset     = ($urandom_range(0, 99) != 0);
            req_valid = ($urandom_range(0, 3) != 0);
            MemWrite  = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 9);
            if (sel < 7)       DataAdr = 13'($urandom_range(0, 15));
            else if (sel == 7) DataAdr = 13'd220;
            else if (sel == 8) DataAdr = 13'($urandom_range(2048, 8191));
            else               DataAdr = 13'($urandom);
            WriteData = ($urandom_range(0, 7) == 0) ? 16'h0060 : 16'($urandom);
        end
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        repeat (20) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Memory-side responder for the pipelined core's data bus: the slave end of the MemWrite/DataAdr/WriteData/ReadData interface.
- Serves word reads and writes from an internal RAM, inserts a programmable number of wait states and stalls the core until acknowledge.
- Counts committed writes and, optionally, checks for the completion signature write in hardware, so pass/fail reaches a GPIO LED without a simulator.

Parameters:
ADDR_W, 13, bus word-address width
DATA_W, 16, bus data width
DEPTH, 2048, implemented RAM words; addresses >= DEPTH are out of range
WAIT_STATES, 2, idle cycles between request accept and ack (0..15)
DONE_ADDR, 220, signature address (used only with DONE_CHECK_EN)
DONE_VALUE, 16'h0060, expected signature data (used only with DONE_CHECK_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low; 0 on a rising edge resets the block
req_valid  in  1  core requests a bus access this cycle
MemWrite  in  1  1 = write, 0 = read; sampled with req_valid
DataAdr  in  ADDR_W  word address
WriteData  in  DATA_W  write data
ReadData  out  DATA_W  read data, valid while ack=1
ack  out  1  one-cycle transaction-complete pulse
stall  out  1  combinational: req_valid & ~ack; core freezes its pipeline while 1
err  out  1  pulses with ack when address >= DEPTH
wr_count  out  16  committed in-range writes, saturates at 16'hFFFF
pass  out  1  sticky signature-match flag
fail  out  1  sticky signature-mismatch flag

Behaviour:
- Reset (reset=0 at clk edge): state=IDLE; ReadData=0, ack=0, err=0, wr_count=0, pass=0, fail=0. RAM contents are not cleared.
- FSM IDLE -> WAIT -> ACK -> IDLE:
  - IDLE: if req_valid, latch DataAdr, WriteData and MemWrite; load cnt=WAIT_STATES; go to WAIT, or go straight to ACK when WAIT_STATES=0.
  - WAIT: decrement cnt; at cnt==1 go to ACK.
  - ACK: ack=1 for exactly one cycle.
    - Read: ReadData = RAM[latched addr].
    - Write: RAM written and wr_count incremented on the edge that leaves ACK.
    - Then return to IDLE.
- Latency: ack rises WAIT_STATES+1 cycles after the accepting edge. Back-to-back throughput is one transaction per WAIT_STATES+2 cycles.
- Request inputs are ignored outside IDLE, because the latched copy is used. A req_valid still high in the cycle after ACK starts a new transaction.
- ReadData holds its last value after ack and is 0 for writes.
- Out-of-range address: read returns 16'hDEAD, write is discarded (wr_count unchanged), err=1 together with ack.
- Reset mid-transaction: the transaction is dropped, no RAM write occurs, and ack never fires.
- wr_count at 16'hFFFF stays at 16'hFFFF.

Optional Feature:
- Macro: BUS_MEM_RESPONDER_DONE_CHECK_EN.
- Defined: the first committed write to DONE_ADDR sets pass=1 if its data equals DONE_VALUE, otherwise sets fail=1. Both flags are sticky until reset, and later writes to DONE_ADDR do not change them. pass and fail are never both 1.
- Undefined: pass and fail are tied to 0, and the DONE_ADDR/DONE_VALUE parameters are unused.

Decomposition:
- Package bus_mem_pkg: state enum (IDLE, WAIT, ACK), ADDR_W/DATA_W defaults, the 16'hDEAD out-of-range constant, and a default DONE_ADDR/DONE_VALUE.
- One sub-module, bus_ram: single-port synchronous RAM (DEPTH x DATA_W) with a write enable, so the FPGA tool infers M9K blocks.

Test Plan:
- Write 16'h1234 to addr 5, then read addr 5 (WAIT_STATES=2) -> each ack comes 3 cycles after accept; read returns 16'h1234; wr_count=1; stall high until ack.
- WAIT_STATES=0, read addr 7 -> ack on the cycle after accept; back-to-back reads are accepted every 2 cycles.
- Read addr 4095 with DEPTH=2048 -> ReadData=16'hDEAD and err=1 with ack. Write to addr 4095 -> err=1, wr_count unchanged.
- Drive reset=0 during WAIT of a write to addr 9 holding old value 16'h00AA -> no ack; a later read of addr 9 returns 16'h00AA.
- DONE_CHECK_EN: write 16'h0060 to addr 220 -> pass=1, fail=0. Then write 16'h0000 to addr 220 -> pass stays 1. Separate run writing 16'h0061 first -> fail=1.
- Force wr_count to 16'hFFFE, issue 3 writes -> wr_count holds at 16'hFFFF.
